// File: rtl/eq_channel_sequencer.sv
// -----------------------------------------------------------------------------
// eq_channel_sequencer
//
// Equalizer channel controller. Each audio sample is moved from the ADC through
// the DSP to the DAC, one channel at a time in round-robin order. Per-band gains
// are written over APB into a shadow bank. They are copied into the active bank
// at frame boundaries. A stalled handshake drives the block into FAULT.
//
// Ports
//   Clk, Reset_            clock (rising edge), asynchronous active-low reset
//   PSel/PEnable/PWrite    APB control; write strobe is PSel & PEnable & PWrite
//   PAddr, PWData          APB address (word aligned) and write data
//   PRData                 APB read data, combinational on PAddr
//   AdcReq/AdcAck/AdcData  ADC sample handshake
//   DspReq/DspAck          DSP handshake; DspSample out, DspResult in
//   DacReq/DacAck/DacData  DAC handshake
//   Chan                   channel in progress, shared by ADC, DSP and DAC
//   GainBus                active gains, band k at [k*GAIN_W +: GAIN_W]
//   GainCommit             one-cycle pulse when the active gains change
//   Running, Fault         status flags
// -----------------------------------------------------------------------------
module eq_channel_sequencer #(
   parameter int                NUM_BANDS    = 10,
   parameter int                NUM_CHANNELS = 2,
   parameter int                SAMPLE_W     = 16,
   parameter int                GAIN_W       = 16,
   parameter logic [GAIN_W-1:0] GAIN_RESET   = 16'h8000,
   parameter int                TIMEOUT      = 1023
) (
   input  logic                        Clk,
   input  logic                        Reset_,
   input  logic                        PSel,
   input  logic                        PEnable,
   input  logic                        PWrite,
   input  logic [11:0]                 PAddr,
   input  logic [31:0]                 PWData,
   output logic [31:0]                 PRData,
   output logic                        AdcReq,
   input  logic                        AdcAck,
   input  logic [SAMPLE_W-1:0]         AdcData,
   output logic                        DspReq,
   input  logic                        DspAck,
   output logic [SAMPLE_W-1:0]         DspSample,
   input  logic [SAMPLE_W-1:0]         DspResult,
   output logic                        DacReq,
   input  logic                        DacAck,
   output logic [SAMPLE_W-1:0]         DacData,
   output logic [2:0]                  Chan,
   output logic [NUM_BANDS*GAIN_W-1:0] GainBus,
   output logic                        GainCommit,
   output logic                        Running,
   output logic                        Fault
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ADC   = 3'd1,
      S_DSP   = 3'd2,
      S_DAC   = 3'd3,
      S_NEXT  = 3'd4,
      S_FAULT = 3'd5
   } state_t;

   localparam int                GBUS_W    = NUM_BANDS * GAIN_W;
   localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [2:0]        CHAN_LAST = 3'(NUM_CHANNELS - 1);

   state_t              state_q,   state_d;
   logic                en_q,      en_d;
   logic [2:0]          chan_q,    chan_d;
   logic [15:0]         frame_q,   frame_d;
   logic                pending_q, pending_d;
   logic [WAIT_W-1:0]   wcnt_q,    wcnt_d;
   logic [SAMPLE_W-1:0] sample_q,  sample_d;
   logic [SAMPLE_W-1:0] result_q,  result_d;
   logic [GBUS_W-1:0]   shadow_q,  shadow_d;
   logic [GBUS_W-1:0]   active_q,  active_d;
   logic                commit_q,  commit_d;
   logic                adc_req_q, adc_req_d;
   logic                dsp_req_q, dsp_req_d;
   logic                dac_req_q, dac_req_d;

   logic wr_stb, aligned, band_ok;
   logic ctrl_wr, clrf_wr, commit_wr, shadow_wr;
   logic boundary, apply;
   logic unused_pwdata;

   // APB decode; misaligned addresses are treated as unmapped
   assign wr_stb    = PSel & PEnable & PWrite;
   assign aligned   = (PAddr[1:0] == 2'b00);
   assign band_ok   = (int'(PAddr[7:2]) < NUM_BANDS);
   assign ctrl_wr   = wr_stb & aligned & (PAddr[11:2] == 10'd0);
   assign clrf_wr   = ctrl_wr & PWData[1];
   assign commit_wr = wr_stb & aligned & (PAddr[11:2] == 10'd2);
   assign shadow_wr = wr_stb & aligned & (PAddr[11:8] == 4'h1) & band_ok;
   assign unused_pwdata = ^PWData;

   always_comb begin
      state_d   = state_q;
      en_d      = en_q;
      chan_d    = chan_q;
      frame_d   = frame_q;
      pending_d = pending_q;
      wcnt_d    = wcnt_q;
      sample_d  = sample_q;
      result_d  = result_q;
      shadow_d  = shadow_q;
      active_d  = active_q;
      boundary  = 1'b0;
      apply     = 1'b0;

      if (ctrl_wr) en_d = PWData[0];

      unique case (state_q)
         S_IDLE: begin
            boundary = 1'b1;
            if (en_q) begin
               state_d = S_ADC;
               chan_d  = '0;
            end
         end
         S_ADC: begin
            if (AdcAck && adc_req_q) begin
               sample_d = AdcData;
               state_d  = S_DSP;
            end else if (wcnt_q == WAIT_LAST) begin
               state_d = S_FAULT;
            end
         end
         S_DSP: begin
            if (DspAck && dsp_req_q) begin
               result_d = DspResult;
               state_d  = S_DAC;
            end else if (wcnt_q == WAIT_LAST) begin
               state_d = S_FAULT;
            end
         end
         S_DAC: begin
            if (DacAck && dac_req_q) begin
               state_d = S_NEXT;
            end else if (wcnt_q == WAIT_LAST) begin
               state_d = S_FAULT;
            end
         end
         S_NEXT: begin
            // EN is only consulted at the end of a frame, so a frame in
            // progress always completes
            if (chan_q == CHAN_LAST) begin
               boundary = 1'b1;
               chan_d   = '0;
               frame_d  = frame_q + 16'd1;
               state_d  = en_q ? S_ADC : S_IDLE;
            end else begin
               chan_d  = chan_q + 3'd1;
               state_d = S_ADC;
            end
         end
         S_FAULT: begin
            boundary = 1'b1;
            if (clrf_wr) begin
               state_d = S_IDLE;
               chan_d  = '0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Apply uses the pending flag from before this edge, so a COMMIT
      // landing on a boundary waits for the next one. Active takes the
      // shadow value from before any shadow write on the same edge.
      apply = pending_q & boundary;
      if (apply) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end
      if (commit_wr) pending_d = 1'b1;

      for (int k = 0; k < NUM_BANDS; k++) begin
         if (shadow_wr && (int'(PAddr[7:2]) == k))
            shadow_d[k*GAIN_W +: GAIN_W] = PWData[GAIN_W-1:0];
      end

      // Wait counter restarts on every state entry
      if (state_d != state_q)
         wcnt_d = '0;
      else if (state_q == S_ADC || state_q == S_DSP || state_q == S_DAC)
         wcnt_d = wcnt_q + WAIT_W'(1);
   end

   // Requests follow the next state so they are registered yet drop on the
   // same edge that samples their ack
   assign adc_req_d = (state_d == S_ADC);
   assign dsp_req_d = (state_d == S_DSP);
   assign dac_req_d = (state_d == S_DAC);
   assign commit_d  = apply;

   always_ff @(posedge Clk or negedge Reset_) begin
      if (!Reset_) begin
         state_q   <= S_IDLE;
         en_q      <= 1'b0;
         chan_q    <= '0;
         frame_q   <= '0;
         pending_q <= 1'b0;
         wcnt_q    <= '0;
         sample_q  <= '0;
         result_q  <= '0;
         shadow_q  <= {NUM_BANDS{GAIN_RESET}};
         active_q  <= {NUM_BANDS{GAIN_RESET}};
         commit_q  <= 1'b0;
         adc_req_q <= 1'b0;
         dsp_req_q <= 1'b0;
         dac_req_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         en_q      <= en_d;
         chan_q    <= chan_d;
         frame_q   <= frame_d;
         pending_q <= pending_d;
         wcnt_q    <= wcnt_d;
         sample_q  <= sample_d;
         result_q  <= result_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         commit_q  <= commit_d;
         adc_req_q <= adc_req_d;
         dsp_req_q <= dsp_req_d;
         dac_req_q <= dac_req_d;
      end
   end

   // Register read mux
   always_comb begin
      PRData = '0;
      if (aligned) begin
         if (PAddr[11:2] == 10'd0) begin
            PRData = {31'd0, en_q};
         end else if (PAddr[11:2] == 10'd1) begin
            PRData = {frame_q, 4'd0, pending_q, chan_q, 1'b0, state_q, 2'b00,
                      Fault, Running};
         end else begin
            for (int k = 0; k < NUM_BANDS; k++) begin
               if (int'(PAddr[7:2]) == k) begin
                  if (PAddr[11:8] == 4'h1) PRData = 32'(shadow_q[k*GAIN_W +: GAIN_W]);
                  if (PAddr[11:8] == 4'h2) PRData = 32'(active_q[k*GAIN_W +: GAIN_W]);
               end
            end
         end
      end
   end

   assign AdcReq     = adc_req_q;
   assign DspReq     = dsp_req_q;
   assign DacReq     = dac_req_q;
   assign DspSample  = sample_q;
   assign DacData    = result_q;
   assign Chan       = chan_q;
   assign GainBus    = active_q;
   assign GainCommit = commit_q;
   assign Running    = (state_q == S_ADC) || (state_q == S_DSP) ||
                       (state_q == S_DAC) || (state_q == S_NEXT);
   assign Fault      = (state_q == S_FAULT);

endmodule
